// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states, opcodes,
// instruction classes and the select/ALU codes driven towards the datapath.
package rv_ctrl_pkg;

  localparam logic [2:0] StFetch  = 3'd0;
  localparam logic [2:0] StDecode = 3'd1;
  localparam logic [2:0] StExec   = 3'd2;
  localparam logic [2:0] StMem    = 3'd3;
  localparam logic [2:0] StWb     = 3'd4;
  localparam logic [2:0] StTrap   = 3'd5;

  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;

  typedef enum logic [3:0] {
    ClsR, ClsIAlu, ClsLui, ClsAuipc, ClsLoad, ClsStore, ClsBranch, ClsJal, ClsJalr, ClsIllegal
  } instr_class_e;

  localparam logic [2:0] ImmI = 3'd0;
  localparam logic [2:0] ImmS = 3'd1;
  localparam logic [2:0] ImmU = 3'd2;
  localparam logic [2:0] ImmB = 3'd3;
  localparam logic [2:0] ImmJ = 3'd4;

  localparam logic [3:0] AluAdd   = 4'd0;
  localparam logic [3:0] AluSub   = 4'd1;
  localparam logic [3:0] AluSll   = 4'd2;
  localparam logic [3:0] AluSlt   = 4'd3;
  localparam logic [3:0] AluSltu  = 4'd4;
  localparam logic [3:0] AluXor   = 4'd5;
  localparam logic [3:0] AluSrl   = 4'd6;
  localparam logic [3:0] AluSra   = 4'd7;
  localparam logic [3:0] AluOr    = 4'd8;
  localparam logic [3:0] AluAnd   = 4'd9;
  localparam logic [3:0] AluPassB = 4'd10;

  localparam logic [1:0] WbAlu = 2'd0;
  localparam logic [1:0] WbMem = 2'd1;
  localparam logic [1:0] WbPc4 = 2'd2;

  localparam logic [1:0] PcPlus4 = 2'd0;
  localparam logic [1:0] PcAlu   = 2'd1;
  localparam logic [1:0] PcJalr  = 2'd2;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier: maps opcode/func3/func7 of the latched IR to an
// instruction class plus the immediate, ALU and operand selects used in EXEC.
module ctrl_decode
  import rv_ctrl_pkg::*;
(
  input  logic [6:0]   opcode,
  input  logic [2:0]   func3,
  input  logic [6:0]   func7,
  output instr_class_e cls,
  output logic [2:0]   imm_sel,
  output logic [3:0]   alu_op,
  output logic         sel_a,
  output logic         sel_b,
  output logic         illegal
);

  logic [3:0] alu_f3;
  logic       f7_ok_r;
  logic       f7_ok_i;

  // func7 = 0x20 is only meaningful for SUB and SRA/SRAI; shift-immediates carry shamt in
  // the low bits so func7 must be exactly 0x00 or 0x20 there.
  assign f7_ok_r = (func7 == 7'h00) ||
                   ((func7 == 7'h20) && ((func3 == 3'd0) || (func3 == 3'd5)));
  assign f7_ok_i = (func3 == 3'd1) ? (func7 == 7'h00) :
                   (func3 == 3'd5) ? ((func7 == 7'h00) || (func7 == 7'h20)) : 1'b1;

  always_comb begin
    case (func3)
      3'd0:    alu_f3 = AluAdd;
      3'd1:    alu_f3 = AluSll;
      3'd2:    alu_f3 = AluSlt;
      3'd3:    alu_f3 = AluSltu;
      3'd4:    alu_f3 = AluXor;
      3'd5:    alu_f3 = func7[5] ? AluSra : AluSrl;
      3'd6:    alu_f3 = AluOr;
      default: alu_f3 = AluAnd;
    endcase
  end

  always_comb begin
    cls     = ClsIllegal;
    imm_sel = ImmI;
    alu_op  = AluAdd;
    sel_a   = 1'b0;
    sel_b   = 1'b0;
    case (opcode)
      OpReg: begin
        if (f7_ok_r) cls = ClsR;
        alu_op = ((func3 == 3'd0) && func7[5]) ? AluSub : alu_f3;
      end
      OpImm: begin
        if (f7_ok_i) cls = ClsIAlu;
        alu_op = alu_f3;
        sel_b  = 1'b1;
      end
      OpLui: begin
        cls     = ClsLui;
        imm_sel = ImmU;
        alu_op  = AluPassB;
        sel_b   = 1'b1;
      end
      OpAuipc: begin
        cls     = ClsAuipc;
        imm_sel = ImmU;
        sel_a   = 1'b1;
        sel_b   = 1'b1;
      end
      OpLoad: begin
        cls   = ClsLoad;
        sel_b = 1'b1;
      end
      OpStore: begin
        cls     = ClsStore;
        imm_sel = ImmS;
        sel_b   = 1'b1;
      end
      // Control transfers compute their target in the ALU; the branch compare is external.
      OpBranch: begin
        cls     = ClsBranch;
        imm_sel = ImmB;
        sel_a   = 1'b1;
        sel_b   = 1'b1;
      end
      OpJal: begin
        cls     = ClsJal;
        imm_sel = ImmJ;
        sel_a   = 1'b1;
        sel_b   = 1'b1;
      end
      OpJalr: begin
        cls   = ClsJalr;
        sel_b = 1'b1;
      end
      default: ;
    endcase
  end

  assign illegal = (cls == ClsIllegal);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback, owns the
// imem/dmem req/ack handshakes and the sticky illegal/bus-timeout trap.
module multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          opcode,
  input  logic [2:0]          func3,
  input  logic [6:0]          func7,
  input  logic                br_taken,
  input  logic                imem_ack,
  input  logic                dmem_ack,
  output logic                imem_req,
  output logic                ir_en,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [2:0]          imm_sel,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                sel_a,
  output logic                sel_b,
  output logic [1:0]          wb_sel,
  output logic                reg_wr,
  output logic                pc_en,
  output logic [1:0]          pc_sel,
  output logic                trap,
  output logic                trap_cause
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            trap_q, trap_d;
  logic            cause_q, cause_d;

  instr_class_e cls;
  logic [2:0]   dec_imm_sel;
  logic [3:0]   dec_alu_op;
  logic         dec_sel_a, dec_sel_b, dec_illegal;
  logic         waiting, timeout_hit, in_instr;

  ctrl_decode u_decode (
    .opcode  (opcode),
    .func3   (func3),
    .func7   (func7),
    .cls     (cls),
    .imm_sel (dec_imm_sel),
    .alu_op  (dec_alu_op),
    .sel_a   (dec_sel_a),
    .sel_b   (dec_sel_b),
    .illegal (dec_illegal)
  );

  assign waiting = ((state_q == StFetch) && !imem_ack) || ((state_q == StMem) && !dmem_ack);
  // Fires on the TIMEOUT-th cycle without ack; an ack in that cycle keeps waiting low.
  assign timeout_hit = (TIMEOUT != 0) && waiting && (cnt_q == CntW'(TIMEOUT - 1));
  assign in_instr = (state_q == StDecode) || (state_q == StExec) ||
                    (state_q == StMem) || (state_q == StWb);

  always_comb begin
    state_d    = state_q;
    trap_d     = trap_q;
    cause_d    = cause_q;
    imem_req   = 1'b0;
    ir_en      = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    wb_sel     = WbAlu;
    reg_wr     = 1'b0;
    pc_en      = 1'b0;
    pc_sel     = PcPlus4;
    imm_sel    = in_instr ? dec_imm_sel : ImmI;
    alu_op     = in_instr ? ALU_OP_W'(dec_alu_op) : '0;
    sel_a      = in_instr && dec_sel_a;
    sel_b      = in_instr && dec_sel_b;
    case (state_q)
      StFetch: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_en   = 1'b1;
          state_d = StDecode;
        end else if (timeout_hit) begin
          state_d = StTrap;
          trap_d  = 1'b1;
          cause_d = 1'b1;
        end
      end
      StDecode: begin
        if (dec_illegal) begin
          state_d = StTrap;
          trap_d  = 1'b1;
          cause_d = 1'b0;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        case (cls)
          ClsR, ClsIAlu, ClsLui, ClsAuipc: state_d = StWb;
          ClsLoad, ClsStore:               state_d = StMem;
          ClsBranch: begin
            pc_en   = 1'b1;
            pc_sel  = br_taken ? PcAlu : PcPlus4;
            state_d = StFetch;
          end
          ClsJal, ClsJalr: begin
            reg_wr  = 1'b1;
            wb_sel  = WbPc4;
            pc_en   = 1'b1;
            pc_sel  = (cls == ClsJal) ? PcAlu : PcJalr;
            state_d = StFetch;
          end
          default: begin
            state_d = StTrap;
            trap_d  = 1'b1;
            cause_d = 1'b0;
          end
        endcase
      end
      StMem: begin
        dmem_req = 1'b1;
        dmem_we  = (cls == ClsStore);
        if (dmem_ack) begin
          if (cls == ClsStore) begin
            pc_en   = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StWb;
          end
        end else if (timeout_hit) begin
          state_d = StTrap;
          trap_d  = 1'b1;
          cause_d = 1'b1;
        end
      end
      StWb: begin
        reg_wr  = 1'b1;
        wb_sel  = (cls == ClsLoad) ? WbMem : WbAlu;
        pc_en   = 1'b1;
        state_d = StFetch;
      end
      StTrap:  ;
      default: state_d = StFetch;
    endcase
    // Everything is quiet in the reset cycle, whatever state is being abandoned.
    if (rst) begin
      imem_req = 1'b0;
      ir_en    = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      imm_sel  = ImmI;
      alu_op   = '0;
      sel_a    = 1'b0;
      sel_b    = 1'b0;
      wb_sel   = WbAlu;
      reg_wr   = 1'b0;
      pc_en    = 1'b0;
      pc_sel   = PcPlus4;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (waiting) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      cnt_q   <= '0;
      trap_q  <= 1'b0;
      cause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      trap_q  <= trap_d;
      cause_q <= cause_d;
    end
  end

  assign trap       = trap_q && !rst;
  assign trap_cause = cause_q && !rst;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks instruction classes, handshake stalls, traps and
// mid-operation reset; inputs change 1 time unit after posedge, outputs sampled at negedge.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       br_taken, imem_ack, dmem_ack;
  logic       imem_req, ir_en, dmem_req, dmem_we;
  logic [2:0] imm_sel;
  logic [3:0] alu_op;
  logic       sel_a, sel_b;
  logic [1:0] wb_sel;
  logic       reg_wr, pc_en;
  logic [1:0] pc_sel;
  logic       trap, trap_cause;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT(16), .ALU_OP_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .func3      (func3),
    .func7      (func7),
    .br_taken   (br_taken),
    .imem_ack   (imem_ack),
    .dmem_ack   (dmem_ack),
    .imem_req   (imem_req),
    .ir_en      (ir_en),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .imm_sel    (imm_sel),
    .alu_op     (alu_op),
    .sel_a      (sel_a),
    .sel_b      (sel_b),
    .wb_sel     (wb_sel),
    .reg_wr     (reg_wr),
    .pc_en      (pc_en),
    .pc_sel     (pc_sel),
    .trap       (trap),
    .trap_cause (trap_cause)
  );

  // ALU-class table: word, alu_op, imm_sel, sel_a, sel_b expected in EXEC
  logic [31:0] alu_w   [7] = '{32'h402081B3, 32'h4020D1B3, 32'h0020B1B3, 32'h0FF0F193,
                               32'h4030D193, 32'h123451B7, 32'h00001197};
  logic [3:0]  alu_exp [7] = '{4'd1, 4'd7, 4'd4, 4'd9, 4'd7, 4'd10, 4'd0};
  logic [2:0]  imm_exp [7] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd2};
  logic        sa_exp  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic        sb_exp  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic load_ir(input logic [31:0] w);
    opcode = w[6:0];
    func3  = w[14:12];
    func7  = w[31:25];
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; br_taken = 1'b0;
    next();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; br_taken = 1'b0;
    load_ir(32'h002081B3);
    next(); next(); mid();
    total++;
    if ({imem_req, ir_en, dmem_req, dmem_we, reg_wr, pc_en, trap} !== 7'd0) begin
      bad++; $display("FAIL reset_strobes got=%b want=0000000",
                      {imem_req, ir_en, dmem_req, dmem_we, reg_wr, pc_en, trap});
    end
    total++;
    if ({alu_op, imm_sel, wb_sel, pc_sel, sel_a, sel_b} !== 13'd0) begin
      bad++; $display("FAIL reset_selects got=%h want=0", {alu_op, imm_sel, wb_sel, pc_sel});
    end
    next(); rst = 1'b0; mid();
    total++;
    if (imem_req !== 1'b1 || ir_en !== 1'b0) begin
      bad++; $display("FAIL reset_first_fetch req=%b ir_en=%b want 1,0", imem_req, ir_en);
    end
    next();
  endtask

  task automatic test_add();
    load_ir(32'h002081B3); imem_ack = 1'b1; mid();
    total++;
    if (imem_req !== 1'b1 || ir_en !== 1'b1) begin
      bad++; $display("FAIL add_fetch req=%b ir_en=%b want 1,1", imem_req, ir_en);
    end
    next(); imem_ack = 1'b0; mid();
    total++;
    if (pc_en !== 1'b0 || ir_en !== 1'b0 || imem_req !== 1'b0) begin
      bad++; $display("FAIL add_decode pc_en=%b ir_en=%b req=%b want 0", pc_en, ir_en, imem_req);
    end
    next(); mid();
    total++;
    if (alu_op !== 4'd0 || sel_b !== 1'b0 || sel_a !== 1'b0 || reg_wr !== 1'b0) begin
      bad++; $display("FAIL add_exec alu=%0d sel_b=%b sel_a=%b reg_wr=%b want 0,0,0,0",
                      alu_op, sel_b, sel_a, reg_wr);
    end
    next(); mid();
    total++;
    if (reg_wr !== 1'b1 || wb_sel !== 2'd0 || pc_en !== 1'b1 || pc_sel !== 2'd0) begin
      bad++; $display("FAIL add_wb reg_wr=%b wb_sel=%0d pc_en=%b pc_sel=%0d want 1,0,1,0",
                      reg_wr, wb_sel, pc_en, pc_sel);
    end
    next(); mid();
    total++;
    if (imem_req !== 1'b1 || pc_en !== 1'b0 || reg_wr !== 1'b0) begin
      bad++; $display("FAIL add_refetch req=%b pc_en=%b reg_wr=%b want 1,0,0",
                      imem_req, pc_en, reg_wr);
    end
    next();
  endtask

  task automatic test_alu_table();
    for (int i = 0; i < 7; i++) begin
      load_ir(alu_w[i]); imem_ack = 1'b1;
      next(); imem_ack = 1'b0;
      next(); mid();
      total++;
      if (alu_op !== alu_exp[i] || imm_sel !== imm_exp[i] || sel_a !== sa_exp[i] ||
          sel_b !== sb_exp[i]) begin
        bad++; $display("FAIL alu_tab[%0d] got alu=%0d imm=%0d a=%b b=%b want %0d,%0d,%b,%b",
                        i, alu_op, imm_sel, sel_a, sel_b, alu_exp[i], imm_exp[i], sa_exp[i],
                        sb_exp[i]);
      end
      next(); mid();
      total++;
      if (pc_en !== 1'b1 || reg_wr !== 1'b1 || wb_sel !== 2'd0) begin
        bad++; $display("FAIL alu_tab_wb[%0d] pc_en=%b reg_wr=%b wb_sel=%0d want 1,1,0",
                        i, pc_en, reg_wr, wb_sel);
      end
      next();
    end
  endtask

  task automatic test_load();
    load_ir(32'h0000A183); imem_ack = 1'b1;
    next(); imem_ack = 1'b0;
    next(); mid();
    total++;
    if (alu_op !== 4'd0 || sel_b !== 1'b1 || imm_sel !== 3'd0 || dmem_req !== 1'b0) begin
      bad++; $display("FAIL lw_exec alu=%0d sel_b=%b imm=%0d dreq=%b want 0,1,0,0",
                      alu_op, sel_b, imm_sel, dmem_req);
    end
    for (int w = 0; w < 3; w++) begin
      next(); dmem_ack = (w == 2); mid();
      total++;
      if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || pc_en !== 1'b0) begin
        bad++; $display("FAIL lw_mem[%0d] dreq=%b we=%b pc_en=%b want 1,0,0",
                        w, dmem_req, dmem_we, pc_en);
      end
    end
    next(); dmem_ack = 1'b0; mid();
    total++;
    if (reg_wr !== 1'b1 || wb_sel !== 2'd1 || pc_en !== 1'b1 || dmem_req !== 1'b0) begin
      bad++; $display("FAIL lw_wb reg_wr=%b wb_sel=%0d pc_en=%b dreq=%b want 1,1,1,0",
                      reg_wr, wb_sel, pc_en, dmem_req);
    end
    next();
  endtask

  task automatic test_branch(input logic taken);
    load_ir(32'h00208463); imem_ack = 1'b1;
    next(); imem_ack = 1'b0;
    next(); br_taken = taken; mid();
    total++;
    if (imm_sel !== 3'd3 || pc_en !== 1'b1 || pc_sel !== {1'b0, taken} || reg_wr !== 1'b0) begin
      bad++; $display("FAIL beq_exec taken=%b imm=%0d pc_en=%b pc_sel=%0d reg_wr=%b want 3,1,%0d,0",
                      taken, imm_sel, pc_en, pc_sel, reg_wr, taken);
    end
    next(); br_taken = 1'b0; mid();
    total++;
    if (imem_req !== 1'b1 || pc_en !== 1'b0) begin
      bad++; $display("FAIL beq_refetch req=%b pc_en=%b want 1,0", imem_req, pc_en);
    end
    next();
  endtask

  task automatic test_jumps();
    load_ir(32'h000080E7); imem_ack = 1'b1;
    next(); imem_ack = 1'b0;
    next(); mid();
    total++;
    if (reg_wr !== 1'b1 || wb_sel !== 2'd2 || pc_en !== 1'b1 || pc_sel !== 2'd2 ||
        imm_sel !== 3'd0 || sel_a !== 1'b0) begin
      bad++; $display("FAIL jalr_exec reg_wr=%b wb=%0d pc_en=%b pc_sel=%0d imm=%0d a=%b",
                      reg_wr, wb_sel, pc_en, pc_sel, imm_sel, sel_a);
    end
    next();
    load_ir(32'h008000EF); imem_ack = 1'b1;
    next(); imem_ack = 1'b0;
    next(); mid();
    total++;
    if (reg_wr !== 1'b1 || wb_sel !== 2'd2 || pc_en !== 1'b1 || pc_sel !== 2'd1 ||
        imm_sel !== 3'd4 || sel_a !== 1'b1) begin
      bad++; $display("FAIL jal_exec reg_wr=%b wb=%0d pc_en=%b pc_sel=%0d imm=%0d a=%b",
                      reg_wr, wb_sel, pc_en, pc_sel, imm_sel, sel_a);
    end
    next();
  endtask

  task automatic test_illegal(input logic [31:0] w);
    load_ir(w); imem_ack = 1'b1;
    next(); imem_ack = 1'b0;
    next(); mid();
    total++;
    if (trap !== 1'b1 || trap_cause !== 1'b0 || pc_en !== 1'b0 || reg_wr !== 1'b0) begin
      bad++; $display("FAIL illegal_trap w=%h trap=%b cause=%b pc_en=%b reg_wr=%b want 1,0,0,0",
                      w, trap, trap_cause, pc_en, reg_wr);
    end
    // Acks arriving with no request outstanding must not disturb the trap.
    imem_ack = 1'b1; dmem_ack = 1'b1;
    repeat (16) next();
    mid();
    total++;
    if (trap !== 1'b1 || trap_cause !== 1'b0 || imem_req !== 1'b0 || ir_en !== 1'b0 ||
        dmem_req !== 1'b0) begin
      bad++; $display("FAIL illegal_hold trap=%b cause=%b req=%b ir_en=%b dreq=%b want 1,0,0,0,0",
                      trap, trap_cause, imem_req, ir_en, dmem_req);
    end
    next();
    do_reset(); mid();
    total++;
    if (trap !== 1'b0 || imem_req !== 1'b1) begin
      bad++; $display("FAIL illegal_rst_clear trap=%b req=%b want 0,1", trap, imem_req);
    end
    next();
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      mid();
      total++;
      if (trap !== 1'b0 || imem_req !== 1'b1) begin
        bad++; $display("FAIL timeout_wait[%0d] trap=%b req=%b want 0,1", i, trap, imem_req);
      end
      next();
    end
    mid();
    total++;
    if (trap !== 1'b1 || trap_cause !== 1'b1 || imem_req !== 1'b0) begin
      bad++; $display("FAIL timeout_trap trap=%b cause=%b req=%b want 1,1,0",
                      trap, trap_cause, imem_req);
    end
    next();
  endtask

  task automatic test_ack_at_limit();
    do_reset();
    load_ir(32'h002081B3);
    repeat (15) next();
    imem_ack = 1'b1; mid();
    total++;
    if (ir_en !== 1'b1 || trap !== 1'b0) begin
      bad++; $display("FAIL limit_ack ir_en=%b trap=%b want 1,0", ir_en, trap);
    end
    next(); imem_ack = 1'b0; mid();
    total++;
    if (trap !== 1'b0 || imem_req !== 1'b0) begin
      bad++; $display("FAIL limit_decode trap=%b req=%b want 0,0", trap, imem_req);
    end
    next(); next(); mid();
    total++;
    if (pc_en !== 1'b1 || reg_wr !== 1'b1) begin
      bad++; $display("FAIL limit_wb pc_en=%b reg_wr=%b want 1,1", pc_en, reg_wr);
    end
    next();
  endtask

  task automatic test_store_and_rst();
    load_ir(32'h0020A223); imem_ack = 1'b1;
    next(); imem_ack = 1'b0;
    next(); mid();
    total++;
    if (imm_sel !== 3'd1 || sel_b !== 1'b1 || alu_op !== 4'd0 || reg_wr !== 1'b0 ||
        pc_en !== 1'b0) begin
      bad++; $display("FAIL sw_exec imm=%0d b=%b alu=%0d reg_wr=%b pc_en=%b want 1,1,0,0,0",
                      imm_sel, sel_b, alu_op, reg_wr, pc_en);
    end
    next(); dmem_ack = 1'b1; mid();
    total++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || pc_en !== 1'b1 || pc_sel !== 2'd0 ||
        reg_wr !== 1'b0) begin
      bad++; $display("FAIL sw_mem dreq=%b we=%b pc_en=%b pc_sel=%0d reg_wr=%b want 1,1,1,0,0",
                      dmem_req, dmem_we, pc_en, pc_sel, reg_wr);
    end
    next(); dmem_ack = 1'b0; mid();
    total++;
    if (imem_req !== 1'b1 || dmem_req !== 1'b0) begin
      bad++; $display("FAIL sw_refetch req=%b dreq=%b want 1,0", imem_req, dmem_req);
    end
    next();
    imem_ack = 1'b1;
    next(); imem_ack = 1'b0;
    next(); next(); mid();
    total++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin
      bad++; $display("FAIL sw2_mem dreq=%b we=%b want 1,1", dmem_req, dmem_we);
    end
    next(); rst = 1'b1; mid();
    total++;
    if (dmem_req !== 1'b0 || pc_en !== 1'b0 || reg_wr !== 1'b0) begin
      bad++; $display("FAIL sw2_rst_cycle dreq=%b pc_en=%b reg_wr=%b want 0,0,0",
                      dmem_req, pc_en, reg_wr);
    end
    next(); rst = 1'b0; mid();
    total++;
    if (imem_req !== 1'b1 || dmem_req !== 1'b0 || pc_en !== 1'b0 || reg_wr !== 1'b0) begin
      bad++; $display("FAIL sw2_after_rst req=%b dreq=%b pc_en=%b reg_wr=%b want 1,0,0,0",
                      imem_req, dmem_req, pc_en, reg_wr);
    end
    next();
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu_table();
    test_load();
    test_branch(1'b1);
    test_branch(1'b0);
    test_jumps();
    test_store_and_rst();
    test_illegal(32'h0000007F);
    test_illegal(32'h022081B3);
    test_timeout();
    test_ack_at_limit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
